// File: rtl/rv32i_inst_encoder_if.sv
// Descriptor-in / encoded-word-out stream bundle of the RV32I instruction encoder.
interface rv32i_inst_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [3:0]        in_alu;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Two-stage RV32I encoder: descriptor -> 32-bit word + word address, 2-cycle latency, valid/ready.
// Range checking of immediates is compiled in only when ENC_RANGE_CHECK_EN is defined.
module rv32i_inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  rv32i_inst_encoder_if.slave bus
);
  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  desc_t             s1_dat;
  logic              s1_vld, s1_rdy;
  logic              s2_vld, s2_rdy, s2_err;
  logic [31:0]       s2_inst;
  logic [ADDR_W-1:0] s2_addr, cnt, cnt_nxt;
  logic              out_hs;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              alu_ok, shift, bad, err;
  logic [31:0]       enc, word;

  assign s2_rdy        = !s2_vld || bus.out_ready;
  assign s1_rdy        = !s1_vld || s2_rdy;
  assign bus.in_ready  = s1_rdy;
  assign out_hs        = s2_vld && bus.out_ready;
  assign bus.out_valid = s2_vld;
  assign bus.out_inst  = s2_inst;
  assign bus.out_addr  = s2_addr;
  assign bus.out_err   = s2_err;

  // A word entering S2 takes the counter value it will have after this edge,
  // so back-to-back words get consecutive addresses and a load applies at once.
  assign cnt_nxt = load_en ? load_addr : cnt + {{(ADDR_W-1){1'b0}}, out_hs};

  always_comb begin
    f3     = 3'b000;
    f7     = 7'h00;
    alu_ok = 1'b1;
    shift  = 1'b0;
    case (s1_dat.alu)
      4'd0:  ;
      4'd1:  f7 = 7'h20;
      4'd3:  f3 = 3'b111;
      4'd4:  f3 = 3'b100;
      4'd5:  f3 = 3'b110;
      4'd6:  begin f3 = 3'b001; shift = 1'b1; end
      4'd7:  begin f3 = 3'b101; shift = 1'b1; end
      4'd8:  begin f3 = 3'b101; f7 = 7'h20; shift = 1'b1; end
      4'd9:  f3 = 3'b010;
      4'd10: f3 = 3'b011;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    enc = '0;
    bad = 1'b0;
    case (s1_dat.cls)
      4'd0: begin
        bad = !alu_ok;
        enc = {f7, s1_dat.rs2, s1_dat.rs1, f3, s1_dat.rd, 7'b0110011};
      end
      4'd1: begin
        bad = !alu_ok || (s1_dat.alu == 4'd1);
        enc = {(shift ? {f7, s1_dat.imm[4:0]} : s1_dat.imm[11:0]),
               s1_dat.rs1, f3, s1_dat.rd, 7'b0010011};
      end
      4'd2: begin
        bad = (s1_dat.alu[2:0] == 3'd3) || (s1_dat.alu[2:0] > 3'd5);
        enc = {s1_dat.imm[11:0], s1_dat.rs1, s1_dat.alu[2:0], s1_dat.rd, 7'b0000011};
      end
      4'd3: begin
        bad = s1_dat.alu[2:0] > 3'd2;
        enc = {s1_dat.imm[11:5], s1_dat.rs2, s1_dat.rs1, s1_dat.alu[2:0],
               s1_dat.imm[4:0], 7'b0100011};
      end
      4'd4: begin
        bad = s1_dat.alu[2:1] == 2'b01;
        enc = {s1_dat.imm[12], s1_dat.imm[10:5], s1_dat.rs2, s1_dat.rs1, s1_dat.alu[2:0],
               s1_dat.imm[4:1], s1_dat.imm[11], 7'b1100011};
      end
      4'd5: enc = {s1_dat.imm[20], s1_dat.imm[10:1], s1_dat.imm[11], s1_dat.imm[19:12],
                   s1_dat.rd, 7'b1101111};
      4'd6: enc = {s1_dat.imm[11:0], s1_dat.rs1, 3'b000, s1_dat.rd, 7'b1100111};
      4'd7: enc = {s1_dat.imm[31:12], s1_dat.rd, 7'b0110111};
      4'd8: enc = {s1_dat.imm[31:12], s1_dat.rd, 7'b0010111};
      default: bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic        rng, fit12;
  logic signed [31:0] simm;
  assign simm  = $signed(s1_dat.imm);
  assign fit12 = (simm >= -32'sd2048) && (simm <= 32'sd2047);

  always_comb begin
    rng = 1'b0;
    case (s1_dat.cls)
      4'd1:       rng = shift ? (s1_dat.imm > 32'd31) : !fit12;
      4'd2, 4'd3, 4'd6: rng = !fit12;
      4'd4:       rng = (simm < -32'sd4096) || (simm > 32'sd4094) || s1_dat.imm[0];
      4'd5:       rng = (simm < -32'sd1048576) || (simm > 32'sd1048574) || s1_dat.imm[0];
      4'd7, 4'd8: rng = s1_dat.imm[11:0] != 12'd0;
      default:    rng = 1'b0;
    endcase
  end

  assign err = bad || rng;
`else
  assign err = bad;
`endif

  assign word = err ? NOP : enc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_dat  <= '0;
      s2_vld  <= 1'b0;
      s2_inst <= '0;
      s2_err  <= 1'b0;
      s2_addr <= '0;
      cnt     <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (flush) begin
        s1_vld <= 1'b0;
        s2_vld <= 1'b0;
      end else begin
        if (s1_rdy) s1_vld <= bus.in_valid;
        if (s1_rdy && bus.in_valid)
          s1_dat <= '{cls: bus.in_class, alu: bus.in_alu, rd: bus.in_rd,
                      rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};
        if (s2_rdy) s2_vld <= s1_vld;
        if (s2_rdy && s1_vld) begin
          s2_inst <= word;
          s2_err  <= err;
          s2_addr <= cnt_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Scoreboard bench for rv32i_inst_encoder: directed descriptors with hand-encoded expected words.
module tb_rv32i_inst_encoder;
  logic       clk = 1'b0;
  logic       reset, flush, load_en;
  logic [9:0] load_addr;

  rv32i_inst_encoder_if #(.ADDR_W(10)) bus ();

  rv32i_inst_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .flush(flush), .load_en(load_en),
    .load_addr(load_addr), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [9:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_bad = 0, cyc = 0;
  int   last_acc = 0, last_pop = 0, prev_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  initial forever begin
    @(negedge clk);
    #3;
    if (bus.out_valid && bus.out_ready) begin
      n_vec++;
      prev_pop = last_pop;
      last_pop = cyc;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got inst %h addr %h, expected nothing", bus.out_inst, bus.out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_inst !== e.inst || bus.out_err !== e.err || bus.out_addr !== e.addr) begin
          n_bad++;
          $display("FAIL word: got inst %h err %b addr %h, expected inst %h err %b addr %h",
                   bus.out_inst, bus.out_err, bus.out_addr, e.inst, e.err, e.addr);
        end
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input logic [3:0] cls, input logic [3:0] alu, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] inst, input logic err, input logic [9:0] addr,
                      input bit push);
    logic acc;
    int   n;
    exp_t e;
    if (push) begin
      e.inst = inst; e.err = err; e.addr = addr;
      sb.push_back(e);
    end
    bus.in_class = cls; bus.in_alu = alu; bus.in_rd = rd;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      #3;
      acc = bus.in_ready;
      @(negedge clk);
      if (acc) break;
      if (++n > 50) begin
        n_vec++; n_bad++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        break;
      end
    end
    last_acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      #3;
      if (sb.size() == 0) break;
      @(negedge clk);
      if (++n > 60) begin
        n_vec++; n_bad++;
        $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
        sb.delete();
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_load(input logic [9:0] a);
    load_addr = a;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  initial begin
    logic [31:0] rng_inst;
    logic        rng_err;
`ifdef ENC_RANGE_CHECK_EN
    rng_inst = 32'h0000_0013; rng_err = 1'b1;
`else
    rng_inst = 32'h8000_0013; rng_err = 1'b0;
`endif
    reset = 1'b1; flush = 1'b0; load_en = 1'b0; load_addr = '0;
    bus.in_valid = 1'b0; bus.in_class = '0; bus.in_alu = '0; bus.in_rd = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;

    send(4'd0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 10'd0, 1'b1);
    drain();
    chk("sub_latency", 32'(last_pop - last_acc), 32'd1);

    do_load(10'd0);
    send(4'd1, 4'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0, 10'd0, 1'b1);
    send(4'd3, 4'd2, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0, 10'd1, 1'b1);
    drain();
    chk("b2b_spacing", 32'(last_pop - prev_pop), 32'd1);

    send(4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0, 10'd2, 1'b1);
    send(4'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF, 1'b0, 10'd3, 1'b1);
    send(4'd1, 4'd0, 5'd0, 5'd0, 5'd0, 32'd2048,      rng_inst,     rng_err, 10'd4, 1'b1);
    send(4'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h003100B3, 1'b0, 10'd5, 1'b1);
    send(4'd9, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h00000013, 1'b1, 10'd6, 1'b1);
    send(4'd0, 4'd2, 5'd1, 5'd2, 5'd3, 32'd0,         32'h00000013, 1'b1, 10'd7, 1'b1);
    send(4'd4, 4'd2, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00000013, 1'b1, 10'd8, 1'b1);
    send(4'd2, 4'd3, 5'd4, 5'd2, 5'd0, 32'd0,         32'h00000013, 1'b1, 10'd9, 1'b1);
    send(4'd1, 4'd8, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093, 1'b0, 10'd10, 1'b1);
    send(4'd2, 4'd2, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFF812203, 1'b0, 10'd11, 1'b1);
    send(4'd7, 4'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 32'h123453B7, 1'b0, 10'd12, 1'b1);
    drain();

    // Stall: two words fill the pipe, the third must wait.
    do_load(10'd0);
    bus.out_ready = 1'b0;
    send(4'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3, 1'b0, 10'd0, 1'b1);
    send(4'd0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 10'd1, 1'b1);
    bus.in_class = 4'd5; bus.in_rd = 5'd1; bus.in_imm = 32'd8; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_hold", bus.out_inst, 32'h003100B3);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(4'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 1'b0, 10'd2, 1'b1);
    drain();

    do_load(10'h3FF);
    send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b0, 10'h3FF, 1'b1);
    send(4'd1, 4'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1'b0, 10'h000, 1'b1);
    drain();

    // Flush with both stages full; the counter must be left alone.
    do_load(10'd5);
    bus.out_ready = 1'b0;
    send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0, 1'b0, 10'd0, 1'b0);
    send(4'd1, 4'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0, 1'b0, 10'd0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #3;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(4'd1, 4'd0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 1'b0, 10'd5, 1'b1);
    drain();

    // Reset while a word is held.
    bus.out_ready = 1'b0;
    send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0, 1'b0, 10'd0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_stall_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall_out_inst", bus.out_inst, 32'd0);
    chk("rst_stall_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32i_inst_encoder.md
# rv32i_inst_encoder

Streaming RV32I instruction encoder: the inverse of the pipeline's instruction decoder. It accepts decoded-form descriptors (class, ALU code, registers, immediate) over a valid/ready handshake. It packs each descriptor into a legal 32-bit RV32I word and emits it with a sequential word address. It sits between the boot/test program generator and instruction memory, and produces the exact field layout the decode stage consumes.

## Interface
- `ADDR_W`, 10: width of the output word-address counter.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `flush` input 1: synchronous; drops all in-flight descriptors.
- `load_en` input 1: synchronous load of the address counter.
- `load_addr` input ADDR_W: value loaded into the address counter.
- `in_valid` input 1: descriptor valid.
- `in_ready` output 1: encoder can accept a descriptor.
- `in_class` input 4: instruction class. 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC. Values 9–15 are illegal.
- `in_alu` input 4: selects the operation, per class.
  - R/I: ALU code, using the decode-stage set: 0 add, 1 sub, 2 lui, 3 and, 4 xor, 5 or, 6 sll, 7 srl, 8 sra, 9 slt, 10 sltu.
  - BRANCH/LOAD/STORE: `in_alu[2:0]` is funct3 directly.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_imm` input 32: signed immediate. Byte offset for BRANCH/JAL. Full upper value for LUI/AUIPC.
- `out_valid` output 1: encoded word valid.
- `out_ready` input 1: consumer accepts the word.
- `out_inst` output 32: encoded instruction.
- `out_addr` output ADDR_W: word address of `out_inst`.
- `out_err` output 1: descriptor was illegal; `out_inst` is NOP.

## Operation
- Two-stage pipeline.
  - S1 registers the descriptor.
  - S2 registers the encoded word, the error flag, and the address.
- Each stage is ready when it is empty or the stage downstream of it is advancing.
- `in_ready` = S1 ready.
- The address counter is copied into S2 when a word enters S2. It increments by 1 on each output handshake (`out_valid && out_ready`) and wraps at 2^ADDR_W.
- Encoding, opcodes per RV32I.
  - R: funct3/funct7 from the ALU code. sub and sra set funct7 = 0x20.
  - I: imm[11:0] = `in_imm[11:0]`. For sll/srl/sra, imm = {funct7, `in_imm[4:0]`}.
  - STORE/BRANCH/JAL: standard RV32I split immediates.
  - LUI/AUIPC: `in_imm[31:12]`.
  - JALR: funct3 = 0.
- Illegal descriptor: S2 outputs `out_inst` = 0x00000013 (`addi x0,x0,0`) with `out_err` = 1. The address still advances. Illegal when:
  - class is 9–15;
  - R with ALU code 2 or >10;
  - I with ALU code 1, 2, or >10;
  - BRANCH funct3 is 2 or 3;
  - LOAD funct3 is not one of 0, 1, 2, 4, 5;
  - STORE funct3 > 2.
- Range errors, only with `ENC_RANGE_CHECK_EN`: I/LOAD/STORE/JALR immediate outside [-2048, 2047]; shift amount > 31; BRANCH outside [-4096, 4094] or odd; JAL outside ±1 MiB or odd; LUI/AUIPC with `in_imm[11:0]` ≠ 0.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_inst` = 0, `out_addr` = 0, `out_err` = 0, both stages empty.
- Latency: a descriptor accepted at cycle N appears on `out_*` at cycle N+2 if not stalled.
- Throughput: 1 per cycle while `out_ready` = 1.
- Back-pressure: `out_*` hold stable while `out_valid && !out_ready`. At most 2 descriptors are in flight; `in_ready` drops only when both stages are full and `out_ready` = 0.
- `flush`: both stages are emptied next cycle, and any input handshake in that cycle is discarded. The counter is not changed.
- `load_en` with a simultaneous output handshake: the load wins. A word already in S2 keeps its captured address.
- `reset` asserted mid-stall: immediate return to reset values; the held word is lost.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: range checks active as listed.
- Not defined: immediates are silently truncated into their fields. Only class/ALU/funct3 illegality raises `out_err`.

## Test plan
- R sub x3,x1,x2 (class 0, alu 1) -> `out_inst` 0x402081B3, `out_err` 0, `out_addr` 0, two cycles after acceptance.
- I addi x5,x0,-1 followed by STORE sw x2,8(x1) (funct3 2), back-to-back -> 0xFFF00293 then 0x0020A423, on consecutive cycles, addresses 0 and 1.
- BRANCH beq x1,x2,-4 -> 0xFE208EE3. JAL x1,+8 -> 0x008000EF.
- With `ENC_RANGE_CHECK_EN`, addi with imm 2048 -> 0x00000013, `out_err` 1, address still increments. Without the macro -> 0x80000013, `out_err` 0.
- `out_ready` = 0 for 5 cycles while 3 descriptors are offered -> 2 accepted, `in_ready` low. After release, all 3 emerge in order at addresses 0, 1, 2 with no loss or duplication.
- `load_addr` = 0x3FF, then 2 words -> addresses 0x3FF then 0x000. `flush` with S2 full -> `out_valid` 0 next cycle, counter unchanged.
